// File: rtl/multicycle_ctrl_if.sv
// Handshake and control bundle between the multi-cycle sequencer and the
// CPU wrapper, instruction memory and datapath blocks.
interface multicycle_ctrl_if;
  logic        start_i;
  logic        imem_req_o;
  logic        imem_ack_i;
  logic [6:0]  opcode_i;
  logic        pc_write_o;
  logic        ir_write_o;
  logic [1:0]  ALUOp_o;
  logic        ALUSrc_o;
  logic        RegWrite_o;
  logic        busy_o;
  logic        illegal_o;
  logic        timeout_o;
  logic [31:0] instr_count_o;

  modport master (
    input  start_i,
    output imem_req_o,
    input  imem_ack_i,
    input  opcode_i,
    output pc_write_o,
    output ir_write_o,
    output ALUOp_o,
    output ALUSrc_o,
    output RegWrite_o,
    output busy_o,
    output illegal_o,
    output timeout_o,
    output instr_count_o
  );

  modport slave (
    output start_i,
    input  imem_req_o,
    output imem_ack_i,
    output opcode_i,
    input  pc_write_o,
    input  ir_write_o,
    input  ALUOp_o,
    input  ALUSrc_o,
    input  RegWrite_o,
    input  busy_o,
    input  illegal_o,
    input  timeout_o,
    input  instr_count_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXEC/WB with imem handshake,
// fetch timeout, sticky fault flags and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  multicycle_ctrl_if.master     bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic {
    OP_R = 1'b0,
    OP_I = 1'b1
  } op_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [7:0]  wait_q, wait_d;
  logic        illegal_q, illegal_d;
  logic        timeout_q, timeout_d;
  logic [31:0] instr_count_q, instr_count_d;

  logic        imem_req;
  logic        pc_write;
  logic        ir_write;
  logic        reg_write;
  logic        busy;
  logic [1:0]  alu_op;
  logic        alu_src;

  // Next-state and strobe decode
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    wait_d        = wait_q;
    illegal_d     = illegal_q;
    timeout_d     = timeout_q;
    instr_count_d = instr_count_q;
    imem_req      = 1'b0;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    busy          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end

      S_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        // An ack on the limit cycle wins over the timeout.
        if (bus.imem_ack_i) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          wait_d   = '0;
          state_d  = S_DECODE;
        end else if (wait_q == WAIT_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_DECODE: begin
        busy = 1'b1;
        case (bus.opcode_i)
          OPC_R: begin
            op_d    = OP_R;
            state_d = S_EXEC;
          end
          OPC_I: begin
            op_d    = OP_I;
            state_d = S_EXEC;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end

      S_EXEC: begin
        busy    = 1'b1;
        state_d = S_WB;
      end

      S_WB: begin
        busy          = 1'b1;
        reg_write     = 1'b1;
        instr_count_d = instr_count_q + 32'd1;
        state_d       = bus.start_i ? S_FETCH : S_IDLE;
        wait_d        = '0;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ALU controls follow the latched instruction class only in EXEC and WB
  always_comb begin
    alu_op  = 2'b00;
    alu_src = 1'b0;
    if (state_q == S_EXEC || state_q == S_WB) begin
      alu_op  = (op_q == OP_R) ? 2'b10 : 2'b11;
      alu_src = (op_q == OP_I);
    end
  end

  always_comb begin
    bus.imem_req_o    = imem_req;
    bus.pc_write_o    = pc_write;
    bus.ir_write_o    = ir_write;
    bus.ALUOp_o       = alu_op;
    bus.ALUSrc_o      = alu_src;
    bus.RegWrite_o    = reg_write;
    bus.busy_o        = busy;
    bus.illegal_o     = illegal_q;
    bus.timeout_o     = timeout_q;
    bus.instr_count_o = instr_count_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= S_IDLE;
      op_q          <= OP_R;
      wait_q        <= '0;
      illegal_q     <= 1'b0;
      timeout_q     <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      wait_q        <= wait_d;
      illegal_q     <= illegal_d;
      timeout_q     <= timeout_d;
      instr_count_q <= instr_count_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle vector table feeding a
// scoreboard that is compared mid-cycle against the DUT outputs.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic        req;
    logic        pcw;
    logic        irw;
    logic [1:0]  aluop;
    logic        src;
    logic        regw;
    logic        busy;
    logic        ill;
    logic        to;
    logic [31:0] cnt;
  } outs_t;

  typedef struct {
    logic       rst;
    logic       start;
    logic       ack;
    logic [6:0] opc;
    outs_t      exp;
    string      tag;
  } vec_t;

  typedef struct {
    outs_t exp;
    string tag;
    int    idx;
  } sb_t;

  localparam logic [6:0] OR  = 7'b0110011;
  localparam logic [6:0] OI  = 7'b0010011;
  localparam logic [6:0] OLD = 7'b0000011;
  localparam logic [6:0] ONP = 7'b0000000;

  logic clk = 1'b0;
  logic rst_n;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.WAIT_MAX(3)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  function automatic outs_t oo(logic req, logic pcw, logic irw, logic [1:0] aop,
                               logic src, logic regw, logic busy, logic ill,
                               logic to, logic [31:0] cnt);
    return {req, pcw, irw, aop, src, regw, busy, ill, to, cnt};
  endfunction

  function automatic outs_t o_idle(logic [31:0] c);
    return oo(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, c);
  endfunction
  function automatic outs_t o_fw(logic [31:0] c);
    return oo(1, 0, 0, 2'b00, 0, 0, 1, 0, 0, c);
  endfunction
  function automatic outs_t o_fa(logic [31:0] c);
    return oo(1, 1, 1, 2'b00, 0, 0, 1, 0, 0, c);
  endfunction
  function automatic outs_t o_dec(logic [31:0] c);
    return oo(0, 0, 0, 2'b00, 0, 0, 1, 0, 0, c);
  endfunction
  function automatic outs_t o_exr(logic [31:0] c);
    return oo(0, 0, 0, 2'b10, 0, 0, 1, 0, 0, c);
  endfunction
  function automatic outs_t o_exi(logic [31:0] c);
    return oo(0, 0, 0, 2'b11, 1, 0, 1, 0, 0, c);
  endfunction
  function automatic outs_t o_wbr(logic [31:0] c);
    return oo(0, 0, 0, 2'b10, 0, 1, 1, 0, 0, c);
  endfunction
  function automatic outs_t o_wbi(logic [31:0] c);
    return oo(0, 0, 0, 2'b11, 1, 1, 1, 0, 0, c);
  endfunction
  function automatic outs_t o_halt(logic ill, logic to, logic [31:0] c);
    return oo(0, 0, 0, 2'b00, 0, 0, 0, ill, to, c);
  endfunction

  function automatic string fmt(outs_t o);
    return $sformatf("req=%b pcw=%b irw=%b aluop=%b src=%b regw=%b busy=%b ill=%b to=%b cnt=%h",
                     o.req, o.pcw, o.irw, o.aluop, o.src, o.regw, o.busy, o.ill, o.to, o.cnt);
  endfunction

  function automatic outs_t sample();
    return {bus.imem_req_o, bus.pc_write_o, bus.ir_write_o, bus.ALUOp_o,
            bus.ALUSrc_o, bus.RegWrite_o, bus.busy_o, bus.illegal_o,
            bus.timeout_o, bus.instr_count_o};
  endfunction

  task automatic expect_true(input string tag, input logic ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s: state=%0d %s", tag, 3'(dut.state_q), fmt(sample()));
    end
  endtask

  task automatic add(input string tag, input logic r, input logic s, input logic a,
                     input logic [6:0] opc, input outs_t e);
    vec_t v;
    v.rst   = r;
    v.start = s;
    v.ack   = a;
    v.opc   = opc;
    v.exp   = e;
    v.tag   = tag;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    sb_t e;
    @(posedge clk);
    #1;
    rst_n          = v.rst;
    bus.start_i    = v.start;
    bus.imem_ack_i = v.ack;
    bus.opcode_i   = v.opc;
    e.exp = v.exp;
    e.tag = v.tag;
    e.idx = vec_no;
    sb_q.push_back(e);
    vec_no++;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_t   e;
      outs_t act;
      e   = sb_q.pop_front();
      act = sample();
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s[%0d]: got %s want %s", e.tag, e.idx, fmt(act), fmt(e.exp));
      end
      if (e.tag == "idle")
        expect_true("idle_state", (3'(dut.state_q) === 3'd0) && (bus.busy_o === 1'b0));
      if (e.tag == "to_halt")
        expect_true("timeout_expired", (bus.timeout_o === 1'b1) && (3'(dut.state_q) === 3'd5));
    end
  end

  initial begin
    rst_n          = 1'b0;
    bus.start_i    = 1'b0;
    bus.imem_ack_i = 1'b0;
    bus.opcode_i   = ONP;

    // Reset and idle; ack and opcode toggles must be ignored
    for (int k = 0; k < 10; k++)
      add("idle", 1, 0, k[0], 7'(k * 13), o_idle(0));

    // Single R-type, start dropped during EXEC, opcode changed after DECODE
    add("r_idle", 1, 1, 0, ONP, o_idle(0));
    add("r_fetch", 1, 1, 1, ONP, o_fa(0));
    add("r_dec", 1, 1, 0, OR, o_dec(0));
    add("r_exec", 1, 0, 0, OI, o_exr(0));
    add("r_wb", 1, 0, 0, ONP, o_wbr(0));
    add("r_after", 1, 0, 0, ONP, o_idle(1));
    add("r_rst", 0, 0, 0, ONP, o_idle(1));

    // Back-to-back I-type, two wait cycles per fetch
    add("i_idle", 1, 1, 0, ONP, o_idle(0));
    for (int n = 0; n < 3; n++) begin
      add("i_fw0", 1, 1, 0, ONP, o_fw(n));
      add("i_fw1", 1, 0, 0, ONP, o_fw(n));
      add("i_fa", 1, 1, 1, ONP, o_fa(n));
      add("i_dec", 1, 1, 1, OI, o_dec(n));
      add("i_exec", 1, 1, 0, OR, o_exi(n));
      add("i_wb", 1, (n < 2) ? 1'b1 : 1'b0, 0, ONP, o_wbi(n));
    end
    add("i_after", 1, 0, 0, ONP, o_idle(3));

    // Illegal opcode: HALT is sticky under start and ack, only reset exits
    add("il_idle", 1, 1, 0, ONP, o_idle(3));
    add("il_fa", 1, 1, 1, ONP, o_fa(3));
    add("il_dec", 1, 1, 0, OLD, o_dec(3));
    for (int k = 0; k < 3; k++)
      add("il_halt", 1, 1, 1, OR, o_halt(1, 0, 3));
    add("il_rst", 0, 1, 0, ONP, o_halt(1, 0, 3));
    add("il_after", 1, 0, 0, ONP, o_idle(0));

    // Timeout: ack withheld for four FETCH cycles
    add("to_idle", 1, 1, 0, ONP, o_idle(0));
    for (int k = 0; k < 4; k++)
      add("to_fw", 1, 1, 0, ONP, o_fw(0));
    add("to_halt", 1, 1, 1, ONP, o_halt(0, 1, 0));
    add("to_rst", 0, 1, 0, ONP, o_halt(0, 1, 0));
    add("to_after", 1, 0, 0, ONP, o_idle(0));

    // Ack on the limit cycle is accepted
    add("bd_idle", 1, 1, 0, ONP, o_idle(0));
    for (int k = 0; k < 3; k++)
      add("bd_fw", 1, 1, 0, ONP, o_fw(0));
    add("bd_fa", 1, 1, 1, ONP, o_fa(0));
    add("bd_dec", 1, 1, 0, OI, o_dec(0));
    add("bd_exec", 1, 1, 0, ONP, o_exi(0));
    add("bd_wb", 1, 0, 0, ONP, o_wbi(0));
    add("bd_after", 1, 0, 0, ONP, o_idle(1));

    // Reset during EXEC: no write-back, count cleared
    add("rm_idle", 1, 1, 0, ONP, o_idle(1));
    add("rm_fa", 1, 1, 1, ONP, o_fa(1));
    add("rm_dec", 1, 1, 0, OR, o_dec(1));
    add("rm_exec", 0, 1, 0, ONP, o_exr(1));
    add("rm_after", 1, 0, 0, ONP, o_idle(0));
    add("rm_idle2", 1, 0, 0, ONP, o_idle(0));

    repeat (3) @(posedge clk);
    #1;
    expect_true("reset_state", (3'(dut.state_q) === 3'd0) && (sample() === o_idle(0)));
    foreach (vecs[i]) run_vec(vecs[i]);

    // Counter wrap: preload 0xFFFFFFFF, let the flop capture it, retire one
    begin
      vec_t w;
      @(negedge clk);
      #1 force dut.instr_count_q = 32'hFFFF_FFFF;
      w = '{rst: 1, start: 1, ack: 0, opc: ONP, exp: o_idle(32'hFFFF_FFFF), tag: "w_idle"};
      run_vec(w);
      @(negedge clk);
      #1 release dut.instr_count_q;
      w = '{rst: 1, start: 1, ack: 1, opc: ONP, exp: o_fa(32'hFFFF_FFFF), tag: "w_fa"};
      run_vec(w);
      w = '{rst: 1, start: 1, ack: 0, opc: OR, exp: o_dec(32'hFFFF_FFFF), tag: "w_dec"};
      run_vec(w);
      w = '{rst: 1, start: 0, ack: 0, opc: ONP, exp: o_exr(32'hFFFF_FFFF), tag: "w_exec"};
      run_vec(w);
      w = '{rst: 1, start: 0, ack: 0, opc: ONP, exp: o_wbr(32'hFFFF_FFFF), tag: "w_wb"};
      run_vec(w);
      w = '{rst: 1, start: 0, ack: 0, opc: ONP, exp: o_idle(0), tag: "w_wrap"};
      run_vec(w);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
